// File: rtl/apb_master_ctrl.sv
// APB master: turns single-beat command/response requests into APB SETUP/ACCESS transfers,
// with a bounded wait-state counter that aborts unresponsive slaves.
module apb_master_ctrl #(
  parameter int AMBA_WORD       = 32,
  parameter int AMBA_ADDR_WIDTH = 20,
  parameter int TIMEOUT         = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic                       cmd_write,
  input  logic [AMBA_ADDR_WIDTH-1:0] cmd_addr,
  input  logic [AMBA_WORD-1:0]       cmd_wdata,
  output logic                       rsp_valid,
  output logic [AMBA_WORD-1:0]       rsp_rdata,
  output logic                       rsp_err,
  output logic [AMBA_ADDR_WIDTH-1:0] PADDR,
  output logic                       PSEL,
  output logic                       PENABLE,
  output logic                       PWRITE,
  output logic [AMBA_WORD-1:0]       PWDATA,
  input  logic [AMBA_WORD-1:0]       PRDATA,
  input  logic                       PREADY
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  state_t        state_r;
  logic [CW-1:0] wait_cnt_r;

  // Ready is gated by reset so a command presented during reset is never seen as accepted.
  assign cmd_ready = (state_r == IDLE) && !rst;

  // Transfer FSM with registered APB and response outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      wait_cnt_r <= '0;
      PADDR      <= '0;
      PSEL       <= 1'b0;
      PENABLE    <= 1'b0;
      PWRITE     <= 1'b0;
      PWDATA     <= '0;
      rsp_valid  <= 1'b0;
      rsp_err    <= 1'b0;
      rsp_rdata  <= '0;
    end else begin
      rsp_valid <= 1'b0;
      case (state_r)
        IDLE: begin
          if (cmd_valid) begin
            PADDR      <= cmd_addr;
            PWRITE     <= cmd_write;
            PWDATA     <= cmd_wdata;
            PSEL       <= 1'b1;
            PENABLE    <= 1'b0;
            wait_cnt_r <= '0;
            state_r    <= SETUP;
          end else begin
            state_r <= IDLE;
          end
        end
        SETUP: begin
          PSEL    <= 1'b1;
          PENABLE <= 1'b1;
          state_r <= ACCESS;
        end
        ACCESS: begin
          // A ready slave wins over a timeout reached on the same edge.
          if (PREADY) begin
            PSEL      <= 1'b0;
            PENABLE   <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b0;
            rsp_rdata <= PWRITE ? '0 : PRDATA;
            state_r   <= IDLE;
          end else if (wait_cnt_r >= CNT_LAST) begin
            wait_cnt_r <= CNT_MAX;
            PSEL       <= 1'b0;
            PENABLE    <= 1'b0;
            rsp_valid  <= 1'b1;
            rsp_err    <= 1'b1;
            rsp_rdata  <= '0;
            state_r    <= IDLE;
          end else begin
            wait_cnt_r <= wait_cnt_r + CW'(1);
          end
        end
        default: begin
          PSEL    <= 1'b0;
          PENABLE <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/apb_master_ctrl.md
APB_MASTER_CTRL -- requirements
Module: apb_master_ctrl

Interface
REQ-001 Parameter AMBA_WORD, default 32, data width of PWDATA/PRDATA/command/response data.
REQ-002 Parameter AMBA_ADDR_WIDTH, default 20, address width of PADDR/cmd_addr.
REQ-003 Parameter TIMEOUT, default 16, max ACCESS cycles waiting for PREADY before abort.
REQ-004 One clock; reset is synchronous and active-high.
REQ-005 clk  in  1  sole clock, all state updates on rising edge.
REQ-006 rst  in  1  synchronous active-high reset.
REQ-007 cmd_valid  in  1  command request present.
REQ-008 cmd_ready  out  1  block accepts command this cycle.
REQ-009 cmd_write  in  1  1=write, 0=read.
REQ-010 cmd_addr  in  AMBA_ADDR_WIDTH  target register address.
REQ-011 cmd_wdata  in  AMBA_WORD  write data (ignored for reads).
REQ-012 rsp_valid  out  1  one-cycle pulse, transfer finished.
REQ-013 rsp_rdata  out  AMBA_WORD  read data, valid with rsp_valid.
REQ-014 rsp_err  out  1  transfer aborted by timeout, valid with rsp_valid.
REQ-015 PADDR  out  AMBA_ADDR_WIDTH  APB address.
REQ-016 PSEL  out  1  APB select.
REQ-017 PENABLE  out  1  APB enable.
REQ-018 PWRITE  out  1  APB direction.
REQ-019 PWDATA  out  AMBA_WORD  APB write data.
REQ-020 PRDATA  in  AMBA_WORD  APB read data from slave.
REQ-021 PREADY  in  1  slave ready; tie 1 for zero-wait slaves.

Function
REQ-022 FSM states IDLE, SETUP, ACCESS; all outputs driven from registers.
REQ-023 cmd_ready SHALL be 1 exactly when state is IDLE.
REQ-024 IDLE: on cmd_valid=1, latch cmd_write/cmd_addr/cmd_wdata into PWRITE/PADDR/PWDATA, go SETUP; else stay.
REQ-025 SETUP (one cycle): PSEL=1, PENABLE=0; unconditionally go ACCESS.
REQ-026 ACCESS: PSEL=1, PENABLE=1; PADDR/PWRITE/PWDATA held stable from SETUP through ACCESS.
REQ-027 ACCESS with PREADY=1 at rising edge: complete; next cycle PSEL=0, PENABLE=0, rsp_valid=1, rsp_err=0, state IDLE.
REQ-028 On completed read, rsp_rdata = PRDATA sampled at completing edge; on write rsp_rdata=0.
REQ-029 Wait-state counter clears on SETUP entry, increments each ACCESS cycle with PREADY=0, saturates; never wraps.
REQ-030 When counter reaches TIMEOUT with PREADY=0: abort; next cycle PSEL=0, PENABLE=0, rsp_valid=1, rsp_err=1, rsp_rdata=0, state IDLE.
REQ-031 PREADY=1 on the same edge counter reaches TIMEOUT: normal completion wins, rsp_err=0.
REQ-032 Zero-wait transfer latency: accept edge to rsp_valid = 3 cycles; back-to-back command accepted in the rsp_valid cycle (min 3 cycles per transfer).
REQ-033 rsp_valid high exactly one cycle per accepted command; rsp_rdata/rsp_err hold until next rsp_valid.
REQ-034 PREADY/PRDATA ignored outside ACCESS; cmd_* ignored outside IDLE.
REQ-035 PENABLE=1 only when PSEL=1; PSEL never deasserts between SETUP and ACCESS of the same transfer.

Reset
REQ-036 rst=1 at rising edge: state IDLE, PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0, rsp_valid=0, rsp_err=0, rsp_rdata=0, counter=0.
REQ-037 Reset mid-transfer (SETUP or ACCESS) aborts silently: no rsp_valid issued for that command.
REQ-038 cmd_ready=0 while rst=1; cmd_valid during reset is not accepted.

Verification
REQ-039 Write 0x0000_0007 to addr 0x4, PREADY=1 -> PSEL rises 1 cycle after accept, PENABLE next cycle, PWDATA=7 stable, rsp_valid 3 cycles after accept, rsp_err=0.
REQ-040 Read addr 0x8, PREADY=1, PRDATA=0xA5A5_0001 -> rsp_rdata=0xA5A5_0001, PWRITE=0 throughout.
REQ-041 Read with PREADY low 3 ACCESS cycles then high -> PENABLE high 4 cycles, rsp_valid 6 cycles after accept, rsp_err=0.
REQ-042 PREADY held 0, TIMEOUT=16 -> abort after 16 ACCESS cycles, rsp_valid=1, rsp_err=1, rsp_rdata=0, PSEL=0.
REQ-043 cmd_valid held high with 2 writes queued -> second accepted in first rsp_valid cycle, SETUP of second immediately follows.
REQ-044 rst=1 during ACCESS -> next cycle PSEL=0, PENABLE=0, no rsp_valid, cmd_ready=1 after rst deasserts.
